// File: rtl/bkm_step_scoreboard_pkg.sv
// Shared definitions for the BKM step-checker scoreboard.
//   - run-state encoding (also driven onto the 2-bit 'state' output)
//   - bit positions of the {Y,X,v,u} channels inside war_vec / err_vec
package bkm_step_scoreboard_pkg;

  // The encodings are externally visible on the state port, so they are pinned explicitly.
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StDone  = 2'b10,
    StAbort = 2'b11
  } bkm_state_e;

  // Channel bit indices in war_vec / err_vec: {Y,X,v,u}.
  localparam int unsigned ChkBitU = 0;
  localparam int unsigned ChkBitV = 1;
  localparam int unsigned ChkBitX = 2;
  localparam int unsigned ChkBitY = 3;

  localparam int unsigned ChkVecW = 4;

endpackage

// File: rtl/bkm_peak_tracker.sv
// Peak-magnitude tracker for one signed delta channel.
// Holds the largest |delta_i| seen since the last clear. The magnitude is exact in
// W-bit unsigned, so the most negative input -2^(W-1) yields 2^(W-1).
//
// Ports:
//   clk_i     clock, rising edge
//   srst_ni   synchronous active-low reset (clears the peak)
//   clr_i     clear the peak to 0 (start of a new run)
//   sample_i  compare-and-update this cycle
//   delta_i   signed two's-complement delta
//   peak_o    registered unsigned peak magnitude
module bkm_peak_tracker #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         srst_ni,
  input  logic         clr_i,
  input  logic         sample_i,
  input  logic [W-1:0] delta_i,
  output logic [W-1:0] peak_o
);

  logic [W-1:0] mag;
  logic [W-1:0] peak_d, peak_q;

  // Two's-complement negate in W bits; -2^(W-1) maps onto itself, which read
  // as unsigned is exactly 2^(W-1).
  always_comb begin
    mag = delta_i;
    if (delta_i[W-1]) begin
      mag = ~delta_i + W'(1);
    end
  end

  always_comb begin
    peak_d = peak_q;
    if (clr_i) begin
      peak_d = '0;
    end else if (sample_i && (mag > peak_q)) begin
      peak_d = mag;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!srst_ni) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak_o = peak_q;

endmodule

// File: rtl/bkm_step_scoreboard.sv
// BKM step scoreboard.
// Collects per-run statistics from a step checker: sample count, samples with any
// warning, samples with any error, and the peak |delta| on each of the four channels.
// A run starts with 'start', ends with 'stop' (DONE) or aborts once the error count
// reaches MAX_ERR (ABORT, disabled when MAX_ERR is 0). Results stay frozen until the
// next start. All outputs are registered.
//
// Ports:
//   clk, srst_n            clock and synchronous active-low reset
//   enable                 global clock-enable; low freezes all state
//   start, stop            run control
//   chk_valid              checker outputs valid this cycle
//   war_vec, err_vec       per-channel warnings / errors, {Y,X,v,u}
//   delta_u/v, delta_X/Y   signed deltas (WC / WD bits)
//   state, done, pass      FSM state, run finished, run verdict
//   n_samples/n_war/n_err  saturating statistics (WCNT bits)
//   peak_u/v, peak_X/Y     unsigned peak magnitudes
module bkm_step_scoreboard
  import bkm_step_scoreboard_pkg::*;
#(
  parameter int unsigned WC      = 16,
  parameter int unsigned WD      = 64,
  parameter int unsigned WCNT    = 32,
  parameter int unsigned MAX_ERR = 16
) (
  input  logic               clk,
  input  logic               srst_n,
  input  logic               enable,
  input  logic               start,
  input  logic               stop,
  input  logic               chk_valid,
  input  logic [ChkVecW-1:0] war_vec,
  input  logic [ChkVecW-1:0] err_vec,
  input  logic [WC-1:0]      delta_u,
  input  logic [WC-1:0]      delta_v,
  input  logic [WD-1:0]      delta_X,
  input  logic [WD-1:0]      delta_Y,
  output logic [1:0]         state,
  output logic               done,
  output logic               pass,
  output logic [WCNT-1:0]    n_samples,
  output logic [WCNT-1:0]    n_war,
  output logic [WCNT-1:0]    n_err,
  output logic [WC-1:0]      peak_u,
  output logic [WC-1:0]      peak_v,
  output logic [WD-1:0]      peak_X,
  output logic [WD-1:0]      peak_Y
);

  localparam logic [WCNT-1:0] CntOne  = WCNT'(1);
  localparam logic [WCNT-1:0] MaxErrC = WCNT'(MAX_ERR);
  // An abort threshold above the saturation value can never be reached.
  localparam bit AbortEn = (MAX_ERR != 0) &&
                           ((WCNT >= 32) || (64'(MAX_ERR) < (64'd1 << WCNT)));

  bkm_state_e state_d, state_q;
  logic [WCNT-1:0] n_samples_d, n_samples_q;
  logic [WCNT-1:0] n_war_d, n_war_q;
  logic [WCNT-1:0] n_err_d, n_err_q;
  logic done_d, done_q;
  logic pass_d, pass_q;
  logic clr, smp;
  logic war_any, err_any;

  assign war_any = war_vec[ChkBitU] | war_vec[ChkBitV] | war_vec[ChkBitX] | war_vec[ChkBitY];
  assign err_any = err_vec[ChkBitU] | err_vec[ChkBitV] | err_vec[ChkBitX] | err_vec[ChkBitY];

  // Next-state and statistics. With enable low nothing moves; reset is handled in the
  // register process and overrides enable.
  always_comb begin
    state_d     = state_q;
    n_samples_d = n_samples_q;
    n_war_d     = n_war_q;
    n_err_d     = n_err_q;
    clr         = 1'b0;
    smp         = 1'b0;

    if (enable) begin
      unique case (state_q)
        StRun: begin
          // start is ignored while running.
          if (chk_valid) begin
            smp = 1'b1;
            if (!(&n_samples_q)) n_samples_d = n_samples_q + CntOne;
            if (war_any && !(&n_war_q)) n_war_d = n_war_q + CntOne;
            if (err_any && !(&n_err_q)) n_err_d = n_err_q + CntOne;
          end
          // Abort beats a simultaneous stop; a sample on the stop edge is still counted.
          if (AbortEn && smp && err_any && (n_err_d == MaxErrC)) begin
            state_d = StAbort;
          end else if (stop) begin
            state_d = StDone;
          end
        end
        default: begin
          // IDLE, DONE, ABORT: stop is ignored, start opens a fresh run.
          if (start) begin
            state_d     = StRun;
            clr         = 1'b1;
            n_samples_d = '0;
            n_war_d     = '0;
            n_err_d     = '0;
          end
        end
      endcase
    end

    done_d = (state_d == StDone) || (state_d == StAbort);
    pass_d = (state_d == StDone) && (n_err_d == '0) && (n_samples_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state_q     <= StIdle;
      n_samples_q <= '0;
      n_war_q     <= '0;
      n_err_q     <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_samples_q <= n_samples_d;
      n_war_q     <= n_war_d;
      n_err_q     <= n_err_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  bkm_peak_tracker #(.W(WC)) u_peak_u (
    .clk_i    (clk),
    .srst_ni  (srst_n),
    .clr_i    (clr),
    .sample_i (smp),
    .delta_i  (delta_u),
    .peak_o   (peak_u)
  );

  bkm_peak_tracker #(.W(WC)) u_peak_v (
    .clk_i    (clk),
    .srst_ni  (srst_n),
    .clr_i    (clr),
    .sample_i (smp),
    .delta_i  (delta_v),
    .peak_o   (peak_v)
  );

  bkm_peak_tracker #(.W(WD)) u_peak_x (
    .clk_i    (clk),
    .srst_ni  (srst_n),
    .clr_i    (clr),
    .sample_i (smp),
    .delta_i  (delta_X),
    .peak_o   (peak_X)
  );

  bkm_peak_tracker #(.W(WD)) u_peak_y (
    .clk_i    (clk),
    .srst_ni  (srst_n),
    .clr_i    (clr),
    .sample_i (smp),
    .delta_i  (delta_Y),
    .peak_o   (peak_Y)
  );

  assign state     = state_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign n_samples = n_samples_q;
  assign n_war     = n_war_q;
  assign n_err     = n_err_q;

endmodule

// File: tb/tb_bkm_step_scoreboard.sv
// Scoreboard bench for bkm_step_scoreboard. Two instances share one stimulus stream:
//   dut0: WCNT=32, MAX_ERR=4   (abort path)
//   dut1: WCNT=4,  MAX_ERR=0   (saturation, no abort)
// A reference model updates on every rising edge and queues the expected outputs;
// a monitor pops and compares on every falling edge.
module tb_bkm_step_scoreboard;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;
  localparam logic [1:0] StAbort = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        srst_n, enable, start, stop, chk_valid;
  logic [3:0]  war_vec, err_vec;
  logic [15:0] delta_u, delta_v;
  logic [63:0] delta_X, delta_Y;

  logic [1:0]  st0, st1;
  logic        done0, done1, pass0, pass1;
  logic [31:0] ns0, nw0, ne0;
  logic [3:0]  ns1, nw1, ne1;
  logic [15:0] pu0, pv0, pu1, pv1;
  logic [63:0] px0, py0, px1, py1;

  bkm_step_scoreboard #(.WC(16), .WD(64), .WCNT(32), .MAX_ERR(4)) dut0 (
    .clk(clk), .srst_n(srst_n), .enable(enable), .start(start), .stop(stop),
    .chk_valid(chk_valid), .war_vec(war_vec), .err_vec(err_vec),
    .delta_u(delta_u), .delta_v(delta_v), .delta_X(delta_X), .delta_Y(delta_Y),
    .state(st0), .done(done0), .pass(pass0),
    .n_samples(ns0), .n_war(nw0), .n_err(ne0),
    .peak_u(pu0), .peak_v(pv0), .peak_X(px0), .peak_Y(py0)
  );

  bkm_step_scoreboard #(.WC(16), .WD(64), .WCNT(4), .MAX_ERR(0)) dut1 (
    .clk(clk), .srst_n(srst_n), .enable(enable), .start(start), .stop(stop),
    .chk_valid(chk_valid), .war_vec(war_vec), .err_vec(err_vec),
    .delta_u(delta_u), .delta_v(delta_v), .delta_X(delta_X), .delta_Y(delta_Y),
    .state(st1), .done(done1), .pass(pass1),
    .n_samples(ns1), .n_war(nw1), .n_err(ne1),
    .peak_u(pu1), .peak_v(pv1), .peak_X(px1), .peak_Y(py1)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [1:0]       st;
    logic             done;
    logic             pass;
    longint unsigned  ns, nw, ne;
    logic [15:0]      pu, pv;
    logic [63:0]      px, py;
  } exp_t;

  exp_t m[2];
  exp_t q0[$];
  exp_t q1[$];

  function automatic logic [15:0] abs16(input logic [15:0] d);
    int v;
    v = int'($signed(d));
    if (v < 0) v = -v;
    return 16'(v);
  endfunction

  function automatic logic [63:0] abs64(input logic [63:0] d);
    logic signed [64:0] v;
    v = $signed({d[63], d});
    if (v < 0) v = -v;
    return v[63:0];
  endfunction

  task automatic mstep(input int k);
    exp_t s;
    longint unsigned cmax, merr;
    bit ab;
    s    = m[k];
    cmax = (k == 0) ? 64'hFFFF_FFFF : 64'd15;
    merr = (k == 0) ? 64'd4 : 64'd0;
    ab   = 1'b0;
    if (!srst_n) begin
      s.st = StIdle; s.ns = 0; s.nw = 0; s.ne = 0;
      s.pu = 0; s.pv = 0; s.px = 0; s.py = 0;
    end else if (enable) begin
      if (s.st != StRun) begin
        if (start) begin
          s.st = StRun; s.ns = 0; s.nw = 0; s.ne = 0;
          s.pu = 0; s.pv = 0; s.px = 0; s.py = 0;
        end
      end else begin
        if (chk_valid) begin
          if (s.ns < cmax) s.ns = s.ns + 1;
          if (war_vec != 0 && s.nw < cmax) s.nw = s.nw + 1;
          if (err_vec != 0) begin
            if (s.ne < cmax) s.ne = s.ne + 1;
            if (merr != 0 && s.ne == merr) ab = 1'b1;
          end
          if (abs16(delta_u) > s.pu) s.pu = abs16(delta_u);
          if (abs16(delta_v) > s.pv) s.pv = abs16(delta_v);
          if (abs64(delta_X) > s.px) s.px = abs64(delta_X);
          if (abs64(delta_Y) > s.py) s.py = abs64(delta_Y);
        end
        if (ab) s.st = StAbort;
        else if (stop) s.st = StDone;
      end
    end
    s.done = (s.st == StDone) || (s.st == StAbort);
    s.pass = (s.st == StDone) && (s.ne == 0) && (s.ns != 0);
    m[k] = s;
  endtask

  always @(posedge clk) begin
    mstep(0);
    mstep(1);
    q0.push_back(m[0]);
    q1.push_back(m[1]);
  end

  // ---------------- monitor ----------------
  task automatic cmp(input string t, input exp_t e, input logic [1:0] st, input logic dn,
                     input logic pa, input logic [63:0] ns, input logic [63:0] nw,
                     input logic [63:0] ne, input logic [15:0] pu, input logic [15:0] pv,
                     input logic [63:0] px, input logic [63:0] py);
    chk({t, ".state"}, 64'(st), 64'(e.st));
    chk({t, ".done"}, 64'(dn), 64'(e.done));
    chk({t, ".pass"}, 64'(pa), 64'(e.pass));
    chk({t, ".n_samples"}, ns, e.ns);
    chk({t, ".n_war"}, nw, e.nw);
    chk({t, ".n_err"}, ne, e.ne);
    chk({t, ".peak_u"}, 64'(pu), 64'(e.pu));
    chk({t, ".peak_v"}, 64'(pv), 64'(e.pv));
    chk({t, ".peak_X"}, px, e.px);
    chk({t, ".peak_Y"}, py, e.py);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() != 0) begin
      e = q0.pop_front();
      cmp("d0", e, st0, done0, pass0, 64'(ns0), 64'(nw0), 64'(ne0), pu0, pv0, px0, py0);
    end
    if (q1.size() != 0) begin
      e = q1.pop_front();
      cmp("d1", e, st1, done1, pass1, 64'(ns1), 64'(nw1), 64'(ne1), pu1, pv1, px1, py1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    start = 1'b0; stop = 1'b0; chk_valid = 1'b0; war_vec = '0; err_vec = '0;
  endtask

  function automatic int small_rand();
    return int'($urandom_range(0, 6)) - 3;
  endfunction

  initial begin
    srst_n = 1'b0; enable = 1'b1;
    idle();
    delta_u = '0; delta_v = '0; delta_X = '0; delta_Y = '0;
    tick(); tick();
    srst_n = 1'b1;
    chk("reset.state", 64'(st0), 64'(StIdle));
    chk("reset.n_samples", 64'(ns0), 64'd0);

    // Clean run: 10 samples, small deltas, then stop.
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk_valid = 1'b1;
      delta_u = (i == 4) ? 16'sd3 : 16'(small_rand());
      delta_v = 16'(small_rand());
      delta_X = 64'(small_rand());
      delta_Y = 64'(small_rand());
      tick();
    end
    idle(); stop = 1'b1; tick(); stop = 1'b0; tick();
    chk("clean.state", 64'(st0), 64'(StDone));
    chk("clean.n_samples", 64'(ns0), 64'd10);
    chk("clean.n_err", 64'(ne0), 64'd0);
    chk("clean.pass", 64'(pass0), 64'd1);
    chk("clean.peak_u", 64'(pu0), 64'd3);

    // Error abort on dut0 after the 4th erroring sample.
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk_valid = 1'b1; err_vec = 4'b0001;
      tick();
      if (i == 3) chk("abort.state_at4", 64'(st0), 64'(StAbort));
    end
    idle(); tick();
    chk("abort.state", 64'(st0), 64'(StAbort));
    chk("abort.n_err", 64'(ne0), 64'd4);
    chk("abort.n_samples", 64'(ns0), 64'd4);
    chk("abort.pass", 64'(pass0), 64'd0);
    chk("abort.done", 64'(done0), 64'd1);
    chk("abort.d1_n_err", 64'(ne1), 64'd6);

    // Magnitude boundary: most negative value, then a smaller positive one.
    start = 1'b1; tick(); start = 1'b0;
    chk_valid = 1'b1; delta_u = 16'h8000; delta_X = 64'h8000_0000_0000_0000; tick();
    delta_u = 16'h7FFF; delta_X = 64'h7FFF_FFFF_FFFF_FFFF; tick();
    idle(); tick();
    chk("abs.peak_u", 64'(pu0), 64'h8000);
    chk("abs.peak_X", px0, 64'h8000_0000_0000_0000);
    stop = 1'b1; tick(); stop = 1'b0;

    // Stop coinciding with an erroring sample; then start+stop from IDLE.
    start = 1'b1; tick(); start = 1'b0;
    chk_valid = 1'b1; err_vec = 4'b0010; stop = 1'b1; tick();
    idle(); tick();
    chk("simul.n_err", 64'(ne1), 64'd1);
    chk("simul.state", 64'(st1), 64'(StDone));
    chk("simul.pass", 64'(pass1), 64'd0);
    srst_n = 1'b0; tick(); srst_n = 1'b1;
    start = 1'b1; stop = 1'b1; tick(); idle();
    chk("startstop.state", 64'(st0), 64'(StRun));

    // Enable low freezes everything; reset then wins regardless of enable.
    chk_valid = 1'b1; war_vec = 4'b0100; tick(); war_vec = '0; tick();
    chk("en.pre_n_samples", 64'(ns0), 64'd2);
    enable = 1'b0; chk_valid = 1'b1; err_vec = 4'b1111; stop = 1'b1; start = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("en.n_samples", 64'(ns0), 64'd2);
    chk("en.n_err", 64'(ne0), 64'd0);
    chk("en.state", 64'(st0), 64'(StRun));
    srst_n = 1'b0; tick(); srst_n = 1'b1; enable = 1'b1; idle();
    chk("rst.state", 64'(st0), 64'(StIdle));
    chk("rst.n_war", 64'(nw0), 64'd0);
    chk("rst.peak_u", 64'(pu0), 64'd0);
    chk("rst.done", 64'(done0), 64'd0);

    // Saturation on the 4-bit counter instance.
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk_valid = 1'b1; war_vec = 4'b1000; tick();
    end
    idle(); tick();
    chk("sat.n_war", 64'(nw1), 64'd15);
    chk("sat.n_samples", 64'(ns1), 64'd15);
    chk("sat.d0_n_war", 64'(nw0), 64'd20);
    stop = 1'b1; tick(); stop = 1'b0; tick();
    chk("sat.pass", 64'(pass1), 64'd1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      srst_n    = ($urandom_range(0, 99) != 0);
      enable    = ($urandom_range(0, 9) != 0);
      start     = ($urandom_range(0, 19) == 0);
      stop      = ($urandom_range(0, 19) == 0);
      chk_valid = ($urandom_range(0, 9) < 6);
      war_vec   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      err_vec   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0;
      delta_u   = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      delta_v   = 16'($urandom);
      delta_X   = ($urandom_range(0, 7) == 0) ? 64'h8000_0000_0000_0000
                                              : {$urandom, $urandom};
      delta_Y   = {$urandom, $urandom};
      tick();
    end
    srst_n = 1'b1; enable = 1'b1; idle();
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
